stream_buffer: RTL

Parametrised multi-entry valid/ready buffer that generalises the single-stage pipeline slice to DEPTH entries. It adds optional zero-latency fall-through, synchronous flush and an occupancy output. It sits between stream producers and consumers wherever more than two entries of slack are needed, e.g. decoupling fetch from decode or absorbing memory response bursts. Ready toward the producer is always registered-derived, so it never depends combinationally on stream_out.ready.

---
 rtl/stream_buffer_pkg.sv | 27 ++
 rtl/stream_intf.sv | 20 ++
 rtl/stream_buffer_std_register.sv | 29 ++
 rtl/stream_buffer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/stream_buffer_pkg.sv
// Shared definitions for the stream buffer slice: clock/reset description,
// pointer sizing helper and the elaboration-time assertion macro.
`ifndef STREAM_BUFFER_PKG_SV
`define STREAM_BUFFER_PKG_SV

`ifndef STATIC_ASSERT
`define STATIC_ASSERT(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end
`endif

package stream_buffer_pkg;

    // Reset sense shared by every std_register; default describes an active-high reset.
    typedef struct packed {
        logic rst_active_low;
    } std_clock_info_t;

    // Pointer width for a circular store of 'depth' entries, never narrower than 1 bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`endif

// File: rtl/stream_intf.sv
// Valid/ready stream bundle with a typed payload.
interface stream_intf #(
    parameter type T = logic
);
    logic valid;
    logic ready;
    T     payload;

    modport in (
        input  valid,
        input  payload,
        output ready
    );

    modport out (
        output valid,
        output payload,
        input  ready
    );
endinterface

// File: rtl/stream_buffer_std_register.sv
// Enabled register with synchronous reset to a parameterised vector.
module std_register
    import stream_buffer_pkg::*;
#(
    parameter std_clock_info_t         CLOCK_INFO   = 'b0,
    parameter int unsigned             WIDTH        = 1,
    parameter logic [WIDTH-1:0]        RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic rst_active;

    assign rst_active = CLOCK_INFO.rst_active_low ? !rst : rst;

    // Reset has priority over the load enable.
    always_ff @(posedge clk) begin
        if (rst_active) begin
            q <= RESET_VECTOR;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/stream_buffer.sv
// DEPTH-entry circular valid/ready buffer with optional empty-buffer
// fall-through, synchronous flush and registered occupancy.
module stream_buffer
    import stream_buffer_pkg::*;
#(
    parameter std_clock_info_t CLOCK_INFO = 'b0,
    parameter type             T          = logic,
    parameter int              DEPTH      = 4,
    parameter int              BYPASS     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    stream_intf.in                       stream_in,
    stream_intf.out                      stream_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    `STATIC_ASSERT(a_depth_min, DEPTH >= 1, "stream_buffer: DEPTH must be at least 1")
    `STATIC_ASSERT(a_bypass_val, (BYPASS == 0) || (BYPASS == 1), "stream_buffer: BYPASS must be 0 or 1")
    `STATIC_ASSERT(a_in_width, $bits(T) == $bits(stream_in.payload), "stream_buffer: stream_in payload width mismatch")
    `STATIC_ASSERT(a_out_width, $bits(T) == $bits(stream_out.payload), "stream_buffer: stream_out payload width mismatch")

    localparam int unsigned W  = $bits(T);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    logic          empty;
    logic          bypass_mode;
    logic          in_ready;
    logic          out_valid;
    logic          push;
    logic          pop;
    logic          bypass_taken;
    logic          do_write;
    logic          do_read;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  rd_data;

    // Handshake decode: ready depends only on registered count, flush and rst.
    always_comb begin
        empty        = (count_q == '0);
        bypass_mode  = (BYPASS == 1) && empty;
        in_ready     = (count_q != FULL_COUNT) && !flush && !rst;
        out_valid    = (bypass_mode ? stream_in.valid : !empty) && !flush && !rst;
        push         = stream_in.valid && in_ready;
        pop          = out_valid && stream_out.ready;
        // A word that passes straight through is neither stored nor read from storage.
        bypass_taken = bypass_mode && push && pop;
        do_write     = push && !bypass_taken;
        do_read      = pop && !bypass_taken;
    end

    // Next-state for pointers and occupancy; pointers wrap by explicit compare.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (do_write) begin
                wp_d = (wp_q == LAST_PTR) ? '0 : wp_q + PW'(1);
            end
            if (do_read) begin
                rp_d = (rp_q == LAST_PTR) ? '0 : rp_q + PW'(1);
            end
            if (do_write && !do_read) begin
                count_d = count_q + CW'(1);
            end else if (do_read && !do_write) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    std_register #(
        .CLOCK_INFO   (CLOCK_INFO),
        .WIDTH        (PW),
        .RESET_VECTOR ('0)
    ) u_wp (
        .clk (clk),
        .rst (rst),
        .en  (wp_d != wp_q),
        .d   (wp_d),
        .q   (wp_q)
    );

    std_register #(
        .CLOCK_INFO   (CLOCK_INFO),
        .WIDTH        (PW),
        .RESET_VECTOR ('0)
    ) u_rp (
        .clk (clk),
        .rst (rst),
        .en  (rp_d != rp_q),
        .d   (rp_d),
        .q   (rp_q)
    );

    std_register #(
        .CLOCK_INFO   (CLOCK_INFO),
        .WIDTH        (CW),
        .RESET_VECTOR ('0)
    ) u_count (
        .clk (clk),
        .rst (rst),
        .en  (count_d != count_q),
        .d   (count_d),
        .q   (count_q)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        std_register #(
            .CLOCK_INFO   (CLOCK_INFO),
            .WIDTH        (W),
            .RESET_VECTOR ('0)
        ) u_entry (
            .clk (clk),
            .rst (rst),
            .en  (do_write && (wp_q == PW'(i))),
            .d   (stream_in.payload),
            .q   (mem[i])
        );
    end

    // Read mux selecting the entry addressed by the read pointer.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
            if (rp_q == PW'(i)) begin
                rd_data = mem[i];
            end
        end
    end

    assign stream_in.ready    = in_ready;
    assign stream_out.valid   = out_valid;
    assign stream_out.payload = bypass_mode ? stream_in.payload : T'(rd_data);
    assign count              = count_q;

endmodule
